// File: rtl/qm_icache_pkg.sv
// Shared icache definitions: refill FSM encoding and address-split helpers.
// Also used by the icache tag/data arrays.
package qm_icache_pkg;

    typedef enum logic [1:0] {
        StFlush  = 2'd0,
        StIdle   = 2'd1,
        StFill   = 2'd2,
        StCommit = 2'd3
    } refill_state_e;

    localparam int unsigned ADDR_W = 32;

    // Byte-offset bits within a line (word offset plus 2 byte bits).
    function automatic int unsigned offset_bits(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int unsigned index_bits(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned lines,
                                             input int unsigned line_words);
        return ADDR_W - index_bits(lines) - offset_bits(line_words);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0]  addr,
                                              input int unsigned line_words);
        logic [31:0] mask;
        mask = ~((32'd1 << offset_bits(line_words)) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/qm_wrap_counter.sv
// Up-counter that wraps to zero after MAX; wrap flags the terminal count.
module qm_wrap_counter #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned MAX   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = (count == WIDTH'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/qm_icache_refill.sv
// Icache miss/refill sequencer plus tag invalidation sweep after reset and on flush.
// Optional perf counters enabled by defining QM_ICACHE_PERF_EN.
module qm_icache_refill
    import qm_icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 64
) (
    input  logic                                       sys_clk,
    input  logic                                       sys_rst_n,
    input  logic                                       miss_valid,
    input  logic [31:0]                                miss_address,
    input  logic                                       flush_req,
    output logic                                       should_stall,
    output logic                                       mem_req,
    output logic [31:0]                                mem_address,
    input  logic                                       mem_ack,
    input  logic [31:0]                                mem_data,
    output logic                                       fill_we,
    output logic [31:0]                                fill_address,
    output logic [31:0]                                fill_data,
    output logic                                       tag_we,
    output logic [index_bits(LINES)-1:0]               tag_index,
    output logic [tag_bits(LINES, LINE_WORDS)-1:0]     tag_value,
    output logic                                       tag_valid,
    output logic [31:0]                                perf_misses,
    output logic [31:0]                                perf_stalls
);

    localparam int unsigned OW = offset_bits(LINE_WORDS);
    localparam int unsigned IW = index_bits(LINES);
    localparam int unsigned CW = $clog2(LINE_WORDS);
    localparam int unsigned LW = 32 - OW;

    refill_state_e   state;
    logic [LW-1:0]   line;
    logic            flush_pend;
    logic [CW-1:0]   word_cnt;
    logic            word_last;
    logic [IW-1:0]   flush_cnt;
    logic            flush_last;
    logic            miss_take;
    logic            word_inc;
    logic            flush_inc;

    assign miss_take = (state == StIdle) && !flush_req && miss_valid;
    assign word_inc  = (state == StFill) && mem_ack;
    assign flush_inc = (state == StFlush);

    qm_wrap_counter #(
        .WIDTH (CW),
        .MAX   (LINE_WORDS - 1)
    ) u_word_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .inc   (word_inc),
        .clr   (miss_take),
        .count (word_cnt),
        .wrap  (word_last)
    );

    // Wraps back to zero on the last swept line, so every sweep starts at index 0.
    qm_wrap_counter #(
        .WIDTH (IW),
        .MAX   (LINES - 1)
    ) u_flush_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .inc   (flush_inc),
        .clr   (1'b0),
        .count (flush_cnt),
        .wrap  (flush_last)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= StFlush;
            mem_req     <= 1'b0;
            mem_address <= '0;
            flush_pend  <= 1'b0;
            line        <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (flush_req) begin
                        state <= StFlush;
                    end else if (miss_valid) begin
                        line        <= miss_address[31:OW];
                        mem_address <= line_base(miss_address, LINE_WORDS);
                        mem_req     <= 1'b1;
                        state       <= StFill;
                    end
                end
                StFill: begin
                    // A flush never aborts a fill; it is replayed after COMMIT.
                    if (flush_req) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_address <= mem_address + 32'd4;
                        if (word_last) begin
                            mem_req <= 1'b0;
                            state   <= StCommit;
                        end
                    end
                end
                StCommit: begin
                    state <= (flush_pend || flush_req) ? StFlush : StIdle;
                end
                StFlush: begin
                    if (flush_last) begin
                        flush_pend <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: state <= StFlush;
            endcase
        end
    end

    // During FILL this equals mem_address; built from word_cnt to avoid a second adder.
    assign fill_address = {line, word_cnt, 2'b00};
    assign fill_data    = mem_data;
    assign fill_we      = (state == StFill) && mem_ack;

    assign should_stall = (state != StIdle) || miss_valid;

    assign tag_we    = (state == StFlush) || (state == StCommit);
    assign tag_valid = (state == StCommit);
    assign tag_index = (state == StFlush) ? flush_cnt : line[IW-1:0];
    assign tag_value = line[LW-1:IW];

`ifdef QM_ICACHE_PERF_EN
    logic [31:0] miss_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            miss_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (miss_take && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
            if (should_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_misses = miss_cnt;
    assign perf_stalls = stall_cnt;
`else
    assign perf_misses = '0;
    assign perf_stalls = '0;
`endif

endmodule
